// File: rtl/uart_core_cfg.sv
// Parametrised UART with independent TX and RX paths.
// TX: valid/ready accept, start bit, DATA_BITS LSB first, optional parity,
//     STOP_BITS stop bits; every bit lasts 16 baud ticks.
// RX: 2-flop synchronised input, 16x oversampling, mid-bit sampling,
//     parity and framing checks, one-cycle rx_valid with data and flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tx_valid, tx_data        transmit request and payload
//   tx_ready, tx_out         transmitter idle, serial line out (idle high)
//   rx_in                    asynchronous serial line in
//   rx_data, rx_valid        received payload and its one-cycle strobe
//   rx_parity_err            parity mismatch on the strobed frame
//   rx_frame_err             first stop bit sampled low on the strobed frame
//   rx_busy                  receiver inside a frame
module uart_core_cfg #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  // Clocks per oversample tick; must come out >= 1 for the chosen rates.
  localparam int unsigned DIV       = CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam bit          HAS_PAR   = (PARITY != 0);
  localparam bit          ODD_PAR   = (PARITY == 1);

  // Parity bit that completes the frame to the configured ones-count.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return ODD_PAR ? ~(^d) : (^d);
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_nxt;
  logic [DIV_W-1:0]     tx_div, tx_div_nxt;
  logic [3:0]           tx_tick, tx_tick_nxt;
  logic [2:0]           tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
  logic                 tx_par, tx_par_nxt;
  logic                 tx_out_nxt, tx_ready_nxt;
  logic                 tx_tick_c, tx_bit_end_c;

  assign tx_tick_c    = (tx_div == DIV_W'(DIV - 1));
  assign tx_bit_end_c = tx_tick_c && (tx_tick == 4'd15);

  // TX next state: counters restart on accept so the start bit is full length.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_div_nxt   = tx_tick_c ? '0 : tx_div + DIV_W'(1);
    tx_tick_nxt  = tx_tick_c ? tx_tick + 4'd1 : tx_tick;
    tx_bit_nxt   = tx_bit;
    tx_sh_nxt    = tx_sh;
    tx_par_nxt   = tx_par;
    tx_out_nxt   = tx_out;
    tx_ready_nxt = tx_ready;
    case (tx_state)
      TX_IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_state_nxt = TX_START;
          tx_div_nxt   = '0;
          tx_tick_nxt  = 4'd0;
          tx_sh_nxt    = tx_data;
          tx_par_nxt   = par_bit(tx_data);
          tx_out_nxt   = 1'b0;
          tx_ready_nxt = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end_c) begin
          tx_state_nxt = TX_DATA;
          tx_out_nxt   = tx_sh[0];
          tx_sh_nxt    = tx_sh >> 1;
          tx_bit_nxt   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end_c) begin
          if (tx_bit == LAST_DATA) begin
            if (HAS_PAR) begin
              tx_state_nxt = TX_PARITY;
              tx_out_nxt   = tx_par;
            end else begin
              tx_state_nxt = TX_STOP;
              tx_out_nxt   = 1'b1;
              tx_bit_nxt   = 3'd0;
            end
          end else begin
            tx_bit_nxt = tx_bit + 3'd1;
            tx_out_nxt = tx_sh[0];
            tx_sh_nxt  = tx_sh >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end_c) begin
          tx_state_nxt = TX_STOP;
          tx_out_nxt   = 1'b1;
          tx_bit_nxt   = 3'd0;
        end
      end
      TX_STOP: begin
        if (tx_bit_end_c) begin
          if (tx_bit == LAST_STOP) begin
            tx_state_nxt = TX_IDLE;
            tx_ready_nxt = 1'b1;
          end else begin
            tx_bit_nxt = tx_bit + 3'd1;
          end
        end
      end
      default: begin
        tx_state_nxt = TX_IDLE;
        tx_out_nxt   = 1'b1;
        tx_ready_nxt = 1'b1;
      end
    endcase
  end

  // TX registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_div   <= '0;
      tx_tick  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_div   <= tx_div_nxt;
      tx_tick  <= tx_tick_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_sh    <= tx_sh_nxt;
      tx_par   <= tx_par_nxt;
      tx_out   <= tx_out_nxt;
      tx_ready <= tx_ready_nxt;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_state_nxt;
  logic [1:0]           rx_sync;
  logic                 rx_prev;
  logic [DIV_W-1:0]     rx_div, rx_div_nxt;
  logic [3:0]           rx_tick, rx_tick_nxt;
  logic [2:0]           rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
  logic                 rx_par, rx_par_nxt;
  logic [DATA_BITS-1:0] rx_data_nxt;
  logic                 rx_valid_nxt, rx_perr_nxt, rx_ferr_nxt, rx_busy_nxt;
  logic                 rx_s_c, rx_fall_c, rx_tick_c, rx_mid_c;

  assign rx_s_c    = rx_sync[1];
  assign rx_fall_c = rx_prev && !rx_s_c;
  assign rx_tick_c = (rx_div == DIV_W'(DIV - 1));
  // Eighth tick after the start edge, then every 16 ticks: mid-bit.
  assign rx_mid_c  = rx_tick_c && (rx_tick == 4'd7);

  // RX next state: only a real falling edge starts a frame, so a line
  // stuck low after a framing error cannot retrigger.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_div_nxt   = rx_tick_c ? '0 : rx_div + DIV_W'(1);
    rx_tick_nxt  = rx_tick_c ? rx_tick + 4'd1 : rx_tick;
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    rx_par_nxt   = rx_par;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    rx_perr_nxt  = rx_parity_err;
    rx_ferr_nxt  = rx_frame_err;
    rx_busy_nxt  = rx_busy;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall_c) begin
          rx_state_nxt = RX_START;
          rx_busy_nxt  = 1'b1;
          rx_div_nxt   = '0;
          rx_tick_nxt  = 4'd0;
        end
      end
      RX_START: begin
        if (rx_mid_c) begin
          if (rx_s_c) begin
            rx_state_nxt = RX_IDLE;
            rx_busy_nxt  = 1'b0;
          end else begin
            rx_state_nxt = RX_DATA;
            rx_bit_nxt   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_mid_c) begin
          rx_sh_nxt = {rx_s_c, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == LAST_DATA) begin
            rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_nxt = rx_bit + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid_c) begin
          rx_par_nxt   = rx_s_c;
          rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_mid_c) begin
          rx_state_nxt = RX_IDLE;
          rx_busy_nxt  = 1'b0;
          rx_valid_nxt = 1'b1;
          rx_data_nxt  = rx_sh;
          rx_ferr_nxt  = !rx_s_c;
          rx_perr_nxt  = HAS_PAR && (rx_par != par_bit(rx_sh));
        end
      end
      default: begin
        rx_state_nxt = RX_IDLE;
        rx_busy_nxt  = 1'b0;
      end
    endcase
  end

  // RX registers, including the input synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync       <= 2'b11;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_div        <= '0;
      rx_tick       <= 4'd0;
      rx_bit        <= 3'd0;
      rx_sh         <= '0;
      rx_par        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_sync       <= {rx_sync[0], rx_in};
      rx_prev       <= rx_s_c;
      rx_state      <= rx_state_nxt;
      rx_div        <= rx_div_nxt;
      rx_tick       <= rx_tick_nxt;
      rx_bit        <= rx_bit_nxt;
      rx_sh         <= rx_sh_nxt;
      rx_par        <= rx_par_nxt;
      rx_data       <= rx_data_nxt;
      rx_valid      <= rx_valid_nxt;
      rx_parity_err <= rx_perr_nxt;
      rx_frame_err  <= rx_ferr_nxt;
      rx_busy       <= rx_busy_nxt;
    end
  end

endmodule

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
- Parametrised successor to the team's fixed 8N1 UART pair: one block holding both TX and RX paths.
- Configurable data width, parity mode and stop-bit count, with 16x oversampled reception and input synchronisation.
- Reports framing and parity errors and uses a valid/ready transmit handshake.
- Sits between the system bus/FIFO logic and the board serial pins.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bit/s.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  transmit request; holds tx_data stable until accepted.
- tx_data  in  DATA_BITS  payload to send.
- tx_ready  out  1  TX idle, can accept.
- tx_out  out  1  serial line out; idle high.
- rx_in  in  1  asynchronous serial line in.
- rx_data  out  DATA_BITS  last received payload.
- rx_valid  out  1  one-cycle pulse: rx_data and error flags are valid.
- rx_parity_err  out  1  parity mismatch on the frame flagged by rx_valid.
- rx_frame_err  out  1  a stop bit was sampled low on the frame flagged by rx_valid.
- rx_busy  out  1  RX inside a frame.

Behaviour:
- Baud tick:
  - DIV = CLK_FREQ/(BAUD_RATE*16), integer division, must be >= 1.
  - A free-running counter produces a 1-cycle tick every DIV clocks.
  - One bit time = 16 ticks.
  - TX and RX use separate tick counters. RX realigns to the start edge; TX restarts its counter on accept.
- Reset (rst high at a clock edge, from any state, including mid-frame):
  - tx_out=1, tx_ready=1, rx_valid=0, rx_busy=0, rx_data=0, both error flags 0.
  - Both FSMs go to IDLE and synchroniser flops load 1.
  - A frame in progress is abandoned; no rx_valid is produced for it.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - Accept occurs when tx_valid && tx_ready at a clock edge. tx_data is latched, tx_ready drops, and tx_out goes low in the same edge.
  - Each state holds tx_out for 16 ticks. DATA is sent LSB first, DATA_BITS bits.
  - Parity bit:
    - Odd mode: bit value makes the total ones count (data + parity) odd.
    - Even mode: bit value makes the total ones count even.
  - STOP drives 1 for STOP_BITS*16 ticks, then tx_ready=1.
  - A new accept is possible on the cycle tx_ready returns high, giving back-to-back frames with no extra idle.
  - tx_valid while busy is ignored (not queued).
- RX path:
  - rx_in passes through a 2-flop synchroniser before any use.
  - IDLE: a falling edge of the synchronised line enters START and sets rx_busy=1.
  - START, at tick 8 (mid-bit): line high means glitch, return to IDLE with no flags. Line low continues.
  - DATA: sample at mid-bit every 16 ticks, DATA_BITS samples, LSB first.
  - PARITY: one mid-bit sample, compared with the parity computed over the received data.
  - STOP: sample only the first stop bit, at mid-bit. A low sample sets frame_err.
  - Result timing: rx_data, rx_parity_err and rx_frame_err update in the same cycle rx_valid pulses, which is the cycle of the stop-bit sample.
  - After the pulse, rx_busy=0 and the FSM returns to IDLE, ready for the next falling edge. The second stop bit is not checked.
  - Flags hold their value until the next rx_valid. rx_parity_err is always 0 when PARITY=0.
  - After a frame error with the line held low, no new start is detected until the line has been high and falls again.
- Widths: rx_data upper bits do not exist; the port is exactly DATA_BITS wide.

Test Plan:
- Use CLK_FREQ=16_000_000, BAUD_RATE=1_000_000 (DIV=1, 16 clk/bit), with tx_out looped to rx_in.
- 8N1, send 0xA5 -> tx_out: 0 for 16 clk, then bits 1,0,1,0,0,1,0,1 each 16 clk, then 1. tx_ready low for exactly 160 clk. rx_valid pulses once with rx_data=0xA5 and both errors 0.
- 7 data bits, PARITY=2, STOP_BITS=2, send 0x03 -> parity bit 0, frame 11*16=176 clk of tx_ready low. RX gets 0x03, no errors. Then send 0x07 -> parity bit 1.
- Drive rx_in directly with an even-parity frame of 0x01 whose parity bit is 0 -> rx_valid with rx_data=0x01, rx_parity_err=1, rx_frame_err=0.
- Drive rx_in with an 8N1 frame of 0x55 whose stop bit is 0 -> rx_valid with rx_frame_err=1. No second rx_valid while the line stays low.
- Glitch and reset:
  - rx_in low pulse of 5 clk in idle -> no rx_valid; rx_busy rises then returns to 0 by clk 9 after the edge.
  - Assert rst at clk 40 of a TX frame -> tx_out=1 and tx_ready=1 the next cycle, and a new accept then starts a clean frame.
